kbd_scan_fifo: RTL and testbench

KBD_SCAN_FIFO -- requirements
Module: kbd_scan_fifo

---
 rtl/kbd_pkg.sv | 29 ++
 rtl/kbd_scan_fifo_if.sv | 35 +++
 rtl/rise_pulse.sv | 22 ++
 rtl/kbd_scan_fifo.sv | 128 ++++++++++++
 tb/tb_kbd_scan_fifo.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared types and field positions for the keyboard scancode FIFO.
// keyboard_data layout: {5'b0, overflow, ready, shift, scancode}.
package kbd_pkg;

   localparam int KBD_DEPTH = 8;

   localparam int SHIFT_BIT = 8;
   localparam int READY_BIT = 9;
   localparam int OVF_BIT   = 10;

   typedef struct packed {
      logic       shift;
      logic [7:0] code;
   } kbd_entry_t;

   // Assemble the CPU-visible word; the caller supplies an all-zero entry when empty.
   function automatic logic [15:0] kbd_pack(input kbd_entry_t entry,
                                            input logic       ready,
                                            input logic       ovf);
      logic [15:0] word;
      word            = '0;
      word[7:0]       = entry.code;
      word[SHIFT_BIT] = entry.shift;
      word[READY_BIT] = ready;
      word[OVF_BIT]   = ovf;
      return word;
   endfunction

endpackage

// File: rtl/kbd_scan_fifo_if.sv
// Bus between the PS/2 receiver / CPU side and the scancode FIFO.
// The slave modport is the FIFO's view; master is the driver's view.
interface kbd_scan_fifo_if
   import kbd_pkg::*;
#(
   parameter int DEPTH = KBD_DEPTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    scancode;
   logic          oflag;
   logic          on_shift;
   logic          clear_on_read;
   logic [15:0]   keyboard_data;
   logic [CW-1:0] count;

   modport master (
      output scancode,
      output oflag,
      output on_shift,
      output clear_on_read,
      input  keyboard_data,
      input  count
   );

   modport slave (
      input  scancode,
      input  oflag,
      input  on_shift,
      input  clear_on_read,
      output keyboard_data,
      output count
   );

endinterface

// File: rtl/rise_pulse.sv
// One-cycle pulse on each rising edge of a level input.
// The history register follows the input even during reset, so a level held across reset release is not an edge.
module rise_pulse (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic pulse
);

   logic prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_reg <= sig;
      end else begin
         prev_reg <= sig;
      end
   end

   assign pulse = sig && !prev_reg && !reset;

endmodule

// File: rtl/kbd_scan_fifo.sv
// Scancode FIFO between the PS/2 receiver and the CPU: edge-triggered push/pop,
// sticky overflow on a dropped push, head entry presented combinationally from a register array.
module kbd_scan_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = KBD_DEPTH
)(
   input  logic            clk,
   input  logic            reset,
   kbd_scan_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic          push_pulse;
   logic          pop_pulse;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] rd_ptr_next;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          ovf_reg;
   logic          ovf_next;

   kbd_entry_t    mem_reg [DEPTH];
   kbd_entry_t    entry_in;
   kbd_entry_t    head_entry;
   logic [DEPTH-1:0] slot_we;

   logic          empty;
   logic          full;
   logic          pop_accept;
   logic          push_accept;
   logic          overflow_set;

   rise_pulse u_push_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (bus.oflag),
      .pulse (push_pulse)
   );

   rise_pulse u_pop_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (bus.clear_on_read),
      .pulse (pop_pulse)
   );

   assign entry_in = {bus.on_shift, bus.scancode};

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));

   // A pop on empty is dropped; a pop frees room for a push in the same cycle, even when full.
   assign pop_accept   = pop_pulse && !empty;
   assign push_accept  = push_pulse && (!full || pop_accept);
   assign overflow_set = push_pulse && full && !pop_accept;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      ovf_next    = ovf_reg;

      if (push_accept) begin
         wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop_accept) begin
         rd_ptr_next = rd_ptr_reg + AW'(1);
      end

      if (push_accept && !pop_accept) begin
         count_next = count_reg + CW'(1);
      end else if (pop_accept && !push_accept) begin
         count_next = count_reg - CW'(1);
      end

      if (pop_accept) begin
         ovf_next = 1'b0;
      end else if (overflow_set) begin
         ovf_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         ovf_reg    <= ovf_next;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign slot_we[gi] = push_accept && (wr_ptr_reg == AW'(gi));
      end
   endgenerate

   // Storage is deliberately left unreset; the empty check below keeps stale slots hidden.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_we[i]) begin
            mem_reg[i] <= entry_in;
         end
      end
   end

   always_comb begin
      head_entry = '0;
      if (!empty) begin
         head_entry = mem_reg[rd_ptr_reg];
      end
   end

   assign bus.keyboard_data = kbd_pack(head_entry, !empty, ovf_reg);
   assign bus.count         = count_reg;

endmodule

// File: tb/tb_kbd_scan_fifo.sv
// Bench for kbd_scan_fifo: vector table, corner-case sequences and random traffic
// checked against a queue-based model of the FIFO rules.
module tb_kbd_scan_fifo;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk;
   logic reset;

   kbd_scan_fifo_if #(.DEPTH(DEPTH)) bus ();

   kbd_scan_fifo #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Reference model: a queue of {shift, code} entries plus sticky overflow.
   logic [8:0] mq [$];
   logic       m_ovf;
   logic       m_last_o;
   logic       m_last_c;

   typedef struct {
      logic        rst;
      logic        o;
      logic        s;
      logic        c;
      logic [7:0]  code;
      logic [15:0] exp_kbd;
      int          exp_cnt;
   } vec_t;

   vec_t vecs [28];

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_kbd();
      logic [15:0] w;
      w = 16'h0000;
      if (mq.size() != 0) begin
         w[8:0] = mq[0];
         w[9]   = 1'b1;
      end
      w[10] = m_ovf;
      return w;
   endfunction

   task automatic model_step();
      logic push_req;
      logic pop_req;
      if (reset) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         push_req = bus.oflag && !m_last_o;
         pop_req  = bus.clear_on_read && !m_last_c;
         if (pop_req && mq.size() != 0) begin
            void'(mq.pop_front());
            m_ovf = 1'b0;
         end
         if (push_req) begin
            if (mq.size() < DEPTH) mq.push_back({bus.on_shift, bus.scancode});
            else                   m_ovf = 1'b1;
         end
      end
      m_last_o = bus.oflag;
      m_last_c = bus.clear_on_read;
   endtask

   task automatic set_in(input logic r, input logic o, input logic s, input logic c, input logic [7:0] code);
      reset             = r;
      bus.oflag         = o;
      bus.on_shift      = s;
      bus.clear_on_read = c;
      bus.scancode      = code;
   endtask

   // One clock: model follows the edge, DUT compared at the falling edge.
   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check16({tag, " kbd"}, bus.keyboard_data, model_kbd());
      check_int({tag, " count"}, int'(bus.count), mq.size());
   endtask

   task automatic push_code(input logic [7:0] code, input logic s, input string tag);
      set_in(1'b0, 1'b1, s, 1'b0, code);
      tick(tag);
      set_in(1'b0, 1'b0, s, 1'b0, code);
      tick(tag);
   endtask

   task automatic pop_once(input string tag);
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      tick(tag);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick(tag);
   endtask

   task automatic do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick("reset");
      tick("reset");
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick("reset release");
   endtask

   initial begin
      //                rst   o     s     c     code    exp_kbd   cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 16'h031C, 1};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 16'h031C, 1};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 16'h031C, 1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 16'h031C, 1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 16'h025A, 1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 16'h025A, 1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 16'h021C, 1};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 16'h021C, 1};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h32, 16'h021C, 2};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h32, 16'h021C, 2};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h21, 16'h021C, 3};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h21, 16'h021C, 3};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0232, 2};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0232, 2};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0221, 1};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0221, 1};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 0};
      vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0};
      vecs[24] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 16'h0377, 1};
      vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0377, 1};
      vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 0};
      vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0};

      mq.delete();
      m_ovf    = 1'b0;
      m_last_o = 1'b0;
      m_last_c = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);

      for (int i = 0; i < 28; i++) begin
         set_in(vecs[i].rst, vecs[i].o, vecs[i].s, vecs[i].c, vecs[i].code);
         tick($sformatf("vec%0d", i));
         check16($sformatf("vec%0d table kbd", i), bus.keyboard_data, vecs[i].exp_kbd);
         check_int($sformatf("vec%0d table count", i), int'(bus.count), vecs[i].exp_cnt);
         $display("vec %0d: kbd=%h count=%0d", i, bus.keyboard_data, bus.count);
      end

      // Overflow: nine pushes into eight slots, ninth dropped, one pop clears the flag.
      do_reset();
      for (int i = 0; i < 9; i++) push_code(8'h10 + 8'(i), 1'b0, "ovf fill");
      check_int("ovf full count", int'(bus.count), 8);
      check16("ovf full kbd", bus.keyboard_data, 16'h0610);
      pop_once("ovf pop");
      check16("ovf cleared kbd", bus.keyboard_data, 16'h0211);
      check_int("ovf cleared count", int'(bus.count), 7);
      for (int i = 0; i < 7; i++) pop_once("ovf drain");
      check16("ovf drained kbd", bus.keyboard_data, 16'h0000);
      $display("seq overflow: count=%0d", bus.count);

      // Full FIFO with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 8; i++) push_code(8'h40 + 8'(i), 1'b0, "full fill");
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
      tick("full push+pop");
      check_int("full push+pop count", int'(bus.count), 8);
      check16("full push+pop kbd", bus.keyboard_data, 16'h0241);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick("full idle");
      for (int i = 0; i < 7; i++) pop_once("full drain");
      check16("full last entry", bus.keyboard_data, 16'h0299);
      check_int("full last count", int'(bus.count), 1);
      $display("seq full push+pop: kbd=%h", bus.keyboard_data);

      // Reset mid-stream with oflag held high through release.
      do_reset();
      for (int i = 0; i < 5; i++) push_code(8'h60 + 8'(i), 1'b1, "mid fill");
      check_int("mid count5", int'(bus.count), 5);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h66);
      tick("mid reset");
      tick("mid reset");
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h66);
      tick("mid release");
      tick("mid hold");
      check16("mid held kbd", bus.keyboard_data, 16'h0000);
      check_int("mid held count", int'(bus.count), 0);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h66);
      tick("mid fall");
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h66);
      tick("mid rise");
      check16("mid repush kbd", bus.keyboard_data, 16'h0266);
      check_int("mid repush count", int'(bus.count), 1);
      $display("seq reset mid-stream: kbd=%h count=%0d", bus.keyboard_data, bus.count);

      // Random traffic: push-heavy first half, pop-heavy second half.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic r, o, c;
         r = ($urandom_range(0, 99) == 0);
         o = bus.oflag;
         c = bus.clear_on_read;
         if (i < 300) begin
            if ($urandom_range(0, 1) == 0) o = ~o;
            if ($urandom_range(0, 3) == 0) c = ~c;
         end else begin
            if ($urandom_range(0, 3) == 0) o = ~o;
            if ($urandom_range(0, 1) == 0) c = ~c;
         end
         set_in(r, o, 1'($urandom_range(0, 1)), c, 8'($urandom_range(0, 255)));
         tick("rnd");
      end
      $display("random phase: %0d cycles", 600);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
